// File: rtl/divider.sv
// divider: divides CLK by DIV into a square wave CLK_OUT plus a one-cycle TICK at the end of each period
//   DIV     division ratio, integer >= 2 (default 40000: 40 MHz -> 1 kHz)
//   CLK     system clock, rising edge
//   RST     synchronous active-high reset; clears counter and both outputs
//   CLK_OUT registered square wave, low floor(DIV/2) cycles then high for the rest of the period
//   TICK    registered strobe, high during the last cycle of each period
module divider #(
  parameter int DIV = 40000
) (
  input  logic CLK,
  input  logic RST,
  output logic CLK_OUT,
  output logic TICK
);
  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] LOW = W'(DIV / 2);
  if (DIV < 2) begin : g_bad_div
    $error("divider: DIV must be at least 2");
  end
  logic [W-1:0] cnt, cnt_next;
  always_comb cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
  // Outputs are decoded from cnt_next so the registers track the new cnt value
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      CLK_OUT <= 1'b0;
      TICK <= 1'b0;
    end else begin
      cnt <= cnt_next;
      CLK_OUT <= cnt_next >= LOW;
      TICK <= cnt_next == LAST;
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed self-checking bench for divider at DIV = 4, 5, 2 and the default ratio
`timescale 1ns/100ps
module tb_divider;
  logic clk = 1'b0;
  logic rst4 = 1'b1, rst5 = 1'b1, rst2 = 1'b1, rstd = 1'b1;
  logic o4, t4, o5, t5, o2, t2, od, td;
  int tests = 0;
  int fails = 0;

  always #12.5 clk = ~clk;

  divider #(.DIV(4)) dut4 (.CLK(clk), .RST(rst4), .CLK_OUT(o4), .TICK(t4));
  divider #(.DIV(5)) dut5 (.CLK(clk), .RST(rst5), .CLK_OUT(o5), .TICK(t5));
  divider #(.DIV(2)) dut2 (.CLK(clk), .RST(rst2), .CLK_OUT(o2), .TICK(t2));
  divider dutd (.CLK(clk), .RST(rstd), .CLK_OUT(od), .TICK(td));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [0:9] e4o, e4t, e5o, e5t, e2o;
    logic [0:3] m4o, m4t;
    int rise, fall, ticks, tick_at, highs;
    e4o = 10'b0110011001;
    e4t = 10'b0010001000;
    e5o = 10'b0111001110;
    e5t = 10'b0001000010;
    e2o = 10'b1010101010;
    m4o = 4'b0110;
    m4t = 4'b0010;
    // two reset edges on the small dividers; default divider stays in reset
    repeat (2) @(negedge clk);
    check("reset o4", o4, 0);
    check("reset t4", t4, 0);
    check("reset o5", o5, 0);
    check("reset t5", t5, 0);
    check("reset o2", o2, 0);
    check("reset t2", t2, 0);
    rst4 = 1'b0;
    rst5 = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("div4 out e%0d", i + 1), o4, e4o[i]);
      check($sformatf("div4 tick e%0d", i + 1), t4, e4t[i]);
      check($sformatf("div5 out e%0d", i + 1), o5, e5o[i]);
      check($sformatf("div5 tick e%0d", i + 1), t5, e5t[i]);
      check($sformatf("div2 out e%0d", i + 1), o2, e2o[i]);
      check($sformatf("div2 tick e%0d", i + 1), t2, e2o[i]);
      check($sformatf("held rst out e%0d", i + 1), od, 0);
      check($sformatf("held rst tick e%0d", i + 1), td, 0);
    end
    // ten edges leave the DIV=4 counter at 2; pulse reset for one edge
    check("div4 pre-reset out", o4, 1);
    rst4 = 1'b1;
    @(negedge clk);
    check("mid reset out", o4, 0);
    check("mid reset tick", t4, 0);
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("restart out e%0d", i + 1), o4, m4o[i]);
      check($sformatf("restart tick e%0d", i + 1), t4, m4t[i]);
    end
    // default ratio: over one full period from release
    rise = -1;
    fall = -1;
    ticks = 0;
    tick_at = -1;
    highs = 0;
    rstd = 1'b0;
    for (int n = 1; n <= 40000; n++) begin
      @(negedge clk);
      if (od) highs++;
      if (od && rise < 0) rise = n;
      if (!od && rise >= 0 && fall < 0) fall = n;
      if (td) begin
        ticks++;
        tick_at = n;
      end
    end
    check("default rise edge", rise, 20000);
    check("default fall edge", fall, 40000);
    check("default high cycles", highs, 20000);
    check("default tick count", ticks, 1);
    check("default tick edge", tick_at, 39999);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
